// File: rtl/asc_scan_driver.sv
// asc_scan_driver: collects a scan packet from the ASC byte stream, shifts it into the scan chain, strobes update, acks.
// Optional ASC_SCAN_READBACK_EN: count ones read back on scan_out and return that count instead of ACK_BYTE.
module asc_scan_driver #(
  parameter int         PACKET_BYTES = 22,
  parameter int         CLK_DIV      = 50,
  parameter logic [7:0] ACK_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] resp_data,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       scan_clk,
  output logic       scan_en,
  output logic       scan_in,
  output logic       scan_update,
  input  logic       scan_out,
  output logic       busy
);
  localparam int             NBITS     = 8 * PACKET_BYTES;
  localparam int             BCW       = PACKET_BYTES > 1 ? $clog2(PACKET_BYTES) : 1;
  localparam logic [7:0]     DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [8:0]     BIT_LAST  = 9'(NBITS - 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(PACKET_BYTES - 1);
  typedef enum logic [1:0] {COLLECT, SHIFT, UPDATE, RESPOND} state_t;
  state_t         state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [8:0]     bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [7:0]     div_cnt_q, div_cnt_d;
  logic [7:0]     pkt_q [PACKET_BYTES];
  logic [7:0]     pkt_d [PACKET_BYTES];
  logic           scan_clk_q, scan_clk_d, scan_en_q, scan_en_d, scan_in_q, scan_in_d;
  logic           scan_update_q, scan_update_d, resp_valid_q, resp_valid_d, busy_q, busy_d;
  logic [7:0]     resp_data_q, resp_data_d, resp_byte;
`ifdef ASC_SCAN_READBACK_EN
  logic [7:0]     ones_q, ones_d;
  assign resp_byte = ones_q;
`else
  logic           unused_scan_out;
  assign unused_scan_out = scan_out;
  assign resp_byte = ACK_BYTE;
`endif
  assign bit_nxt = bit_cnt_q + 9'd1;
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    div_cnt_d     = div_cnt_q;
    pkt_d         = pkt_q;
    scan_clk_d    = scan_clk_q;
    scan_en_d     = scan_en_q;
    scan_in_d     = scan_in_q;
    scan_update_d = scan_update_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
`ifdef ASC_SCAN_READBACK_EN
    ones_d        = ones_q;
`endif
    case (state_q)
      COLLECT: if (in_valid) begin
        pkt_d[byte_cnt_q] = in_data;
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (byte_cnt_q == BYTE_LAST) begin
          state_d    = SHIFT;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          scan_en_d  = 1'b1;
          scan_clk_d = 1'b0;
          scan_in_d  = pkt_d[0][7];
`ifdef ASC_SCAN_READBACK_EN
          ones_d     = '0;
`endif
        end
      end
      SHIFT: begin
`ifdef ASC_SCAN_READBACK_EN
        if (!scan_clk_q && div_cnt_q == DIV_LAST) ones_d = ones_q + {7'd0, scan_out};
`endif
        if (div_cnt_q != DIV_LAST) div_cnt_d = div_cnt_q + 8'd1;
        else begin
          div_cnt_d = '0;
          if (!scan_clk_q) scan_clk_d = 1'b1;
          else if (bit_cnt_q == BIT_LAST) begin
            state_d       = UPDATE;
            scan_clk_d    = 1'b0;
            scan_en_d     = 1'b0;
            scan_in_d     = 1'b0;
            scan_update_d = 1'b1;
          end else begin
            // next bit launches on the falling scan_clk edge; bytes go MSB first
            bit_cnt_d  = bit_nxt;
            scan_clk_d = 1'b0;
            scan_in_d  = pkt_q[BCW'(bit_nxt >> 3)][~bit_nxt[2:0]];
          end
        end
      end
      UPDATE: begin
        div_cnt_d = div_cnt_q == DIV_LAST ? '0 : div_cnt_q + 8'd1;
        if (div_cnt_q == DIV_LAST) begin
          state_d       = RESPOND;
          scan_update_d = 1'b0;
          resp_valid_d  = 1'b1;
          resp_data_d   = resp_byte;
        end
      end
      RESPOND: if (resp_ready) begin
        state_d      = COLLECT;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
      end
      default: begin
        state_d       = COLLECT;
        byte_cnt_d    = '0;
        bit_cnt_d     = '0;
        div_cnt_d     = '0;
        scan_clk_d    = 1'b0;
        scan_en_d     = 1'b0;
        scan_in_d     = 1'b0;
        scan_update_d = 1'b0;
        resp_valid_d  = 1'b0;
        resp_data_d   = '0;
      end
    endcase
    busy_d = state_d != COLLECT;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= COLLECT;
      byte_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      pkt_q         <= '{default: '0};
      scan_clk_q    <= 1'b0;
      scan_en_q     <= 1'b0;
      scan_in_q     <= 1'b0;
      scan_update_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      busy_q        <= 1'b0;
`ifdef ASC_SCAN_READBACK_EN
      ones_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      div_cnt_q     <= div_cnt_d;
      pkt_q         <= pkt_d;
      scan_clk_q    <= scan_clk_d;
      scan_en_q     <= scan_en_d;
      scan_in_q     <= scan_in_d;
      scan_update_q <= scan_update_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      busy_q        <= busy_d;
`ifdef ASC_SCAN_READBACK_EN
      ones_q        <= ones_d;
`endif
    end
  end
  assign in_ready    = state_q == COLLECT;
  assign scan_clk    = scan_clk_q;
  assign scan_en     = scan_en_q;
  assign scan_in     = scan_in_q;
  assign scan_update = scan_update_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_asc_scan_driver.sv
// tb_asc_scan_driver: randomized packets checked every cycle against a timeline model of the scan driver.
module tb_asc_scan_driver;
  localparam int NB = 22, D = 2, NBITS = 8 * NB, S = 2 * D * NBITS;
  logic clk = 0, reset_n = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_ready, resp_valid, resp_ready = 0;
  logic [7:0] resp_data;
  logic scan_clk, scan_en, scan_in, scan_update, scan_out, busy;
  assign scan_out = scan_in;
  asc_scan_driver #(.PACKET_BYTES(NB), .CLK_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .scan_clk(scan_clk), .scan_en(scan_en), .scan_in(scan_in), .scan_update(scan_update),
    .scan_out(scan_out), .busy(busy));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int rises = 0, en_cyc = 0, upd_cyc = 0;
  logic [NBITS-1:0] cap = '0;
  logic [7:0] pk [NB];
  logic [7:0] m_pkt [$];
  bit m_act = 0;
  int m_t = 0;
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic chkv(string nm, logic [NBITS-1:0] got, logic [NBITS-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [7:0] resp_of(input logic [7:0] p [NB]);
    int ones = 0;
    for (int i = 0; i < NB; i++) ones += $countones(p[i]);
`ifdef ASC_SCAN_READBACK_EN
    return 8'(ones);
`else
    return (ones >= 0) ? 8'hA5 : 8'h00;
`endif
  endfunction
  function automatic logic [NBITS-1:0] stream_of(input logic [7:0] p [NB]);
    logic [NBITS-1:0] v = '0;
    for (int i = 0; i < NB; i++) v = {v[NBITS-9:0], p[i]};
    return v;
  endfunction
  initial forever begin
    @(posedge scan_clk);
    rises++;
    cap = {cap[NBITS-2:0], scan_in};
  end
  // Model: once the last byte lands, every output is a pure function of cycles elapsed (m_t).
  initial forever begin
    logic [7:0] by, e_data;
    logic [7:0] pcopy [NB];
    bit e_en, e_clk, e_in, e_upd, e_rv;
    int bidx;
    @(negedge clk);
    if (!reset_n) begin
      m_act = 0;
      m_pkt.delete();
    end else if (!m_act) begin
      if (in_valid) begin
        m_pkt.push_back(in_data);
        if (m_pkt.size() == NB) begin
          m_act = 1;
          m_t = 0;
        end
      end
    end else if (m_t >= S + D && resp_ready) begin
      m_act = 0;
      m_pkt.delete();
    end else m_t++;
    if (scan_en) en_cyc++;
    if (scan_update) upd_cyc++;
    e_en  = m_act && m_t < S;
    e_clk = e_en && (m_t % (2 * D)) >= D;
    e_upd = m_act && m_t >= S && m_t < S + D;
    e_rv  = m_act && m_t >= S + D;
    chk("in_ready", in_ready, !m_act);
    chk("busy", busy, m_act);
    chk("scan_en", scan_en, e_en);
    chk("scan_clk", scan_clk, e_clk);
    chk("scan_update", scan_update, e_upd);
    chk("resp_valid", resp_valid, e_rv);
    if (e_en) begin
      bidx = m_t / (2 * D);
      by = m_pkt[bidx / 8];
      e_in = by[7 - bidx % 8];
      chk("scan_in", scan_in, e_in);
    end
    if (e_rv) begin
      for (int i = 0; i < NB; i++) pcopy[i] = m_pkt[i];
      e_data = resp_of(pcopy);
      chk("resp_data", resp_data, e_data);
    end
  end
  task automatic send_byte(input logic [7:0] v);
    int k = 0;
    @(negedge clk); #1;
    in_valid = 1;
    in_data = v;
    while (!in_ready && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 2000) chk("send_timeout", 1, 0);
  endtask
  task automatic run_pkt(input bit gaps);
    rises = 0; en_cyc = 0; upd_cyc = 0; cap = '0;
    for (int i = 0; i < NB; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk); #1;
        in_valid = 0;
        in_data = 8'($urandom);
      end
      send_byte(pk[i]);
    end
    @(negedge clk); #1;
    in_valid = 0;
    chk("ready_drop", in_ready, 0);
  endtask
  task automatic finish_pkt(input int hold, input bit pre, input logic [7:0] exp_resp);
    int k = 0;
    resp_ready = pre;
    while (!resp_valid && k < S + 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk("resp_seen", resp_valid, 1);
    chk("resp_lit", resp_data, exp_resp);
    if (!pre) begin
      repeat (hold) begin
        @(negedge clk); #1;
      end
      resp_ready = 1;
    end
    @(negedge clk); #1;
    chk("ready_after_resp", in_ready, 1);
    resp_ready = 0;
    chk("rises", rises, NBITS);
    chk("shift_cycles", en_cyc, S);
    chk("update_cycles", upd_cyc, D);
    chkv("stream", cap, stream_of(pk));
  endtask
  task automatic rand_pkt();
    for (int i = 0; i < NB; i++) pk[i] = 8'($urandom);
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", resp_data, 0);
    #1 reset_n = 1;
    for (int i = 0; i < NB; i++) pk[i] = (i == 0) ? 8'h80 : 8'h00;
    run_pkt(0);
`ifdef ASC_SCAN_READBACK_EN
    finish_pkt(0, 0, 8'h01);
`else
    finish_pkt(0, 0, 8'hA5);
`endif
    chkv("t1_stream_lit", cap, {8'h80, 168'd0});
    for (int i = 0; i < NB; i++) pk[i] = 8'(i);
    run_pkt(0);
`ifdef ASC_SCAN_READBACK_EN
    finish_pkt(0, 1, 8'h2D);
`else
    finish_pkt(0, 1, 8'hA5);
`endif
    chk("t2_byte0", cap[175:168], 8'h00);
    chk("t2_byte1", cap[167:160], 8'h01);
    chk("t2_byte21", cap[7:0], 8'h15);
    rand_pkt();
    run_pkt(1);
    finish_pkt(10, 0, resp_of(pk));
    rand_pkt();
    run_pkt(0);
    repeat (37) @(negedge clk);
    #1 in_valid = 1; in_data = 8'hFF;
    @(negedge clk); #1 in_valid = 0;
    finish_pkt(3, 0, resp_of(pk));
    rand_pkt();
    run_pkt(1);
    finish_pkt(0, 1, resp_of(pk));
    rand_pkt();
    run_pkt(0);
    k = 0;
    while (rises < 50 && k < S) begin
      @(negedge clk);
      k++;
    end
    chk("bit50_reached", rises, 50);
    @(posedge clk); #2 reset_n = 0;
    #1;
    chk("ar_scan_clk", scan_clk, 0);
    chk("ar_scan_en", scan_en, 0);
    chk("ar_scan_in", scan_in, 0);
    chk("ar_scan_update", scan_update, 0);
    chk("ar_resp_valid", resp_valid, 0);
    chk("ar_resp_data", resp_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_in_ready", in_ready, 1);
    @(negedge clk); #1 reset_n = 1;
    rand_pkt();
    run_pkt(0);
    finish_pkt(2, 0, resp_of(pk));
    for (int n = 0; n < 3; n++) begin
      rand_pkt();
      run_pkt(1);
      finish_pkt($urandom_range(0, 6), 1'($urandom_range(0, 1)), resp_of(pk));
    end
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/asc_scan_driver.md
Name: asc_scan_driver

Overview:
- Sits directly downstream of the UART protocol handler on its ASC byte stream.
- Collects one 22-byte scan-chain packet and shifts it serially into the SCuM-V analog scan chain using a divided scan clock.
- Pulses the chain update latch once the packet is shifted in.
- Returns a one-byte completion response to the handler, which forwards it to the host.

Parameters:
- PACKET_BYTES, 22, bytes per scan packet; chain length is 8*PACKET_BYTES bits.
- CLK_DIV, 50, clk cycles per scan_clk half-period; legal range 1..255.
- ACK_BYTE, 8'hA5, response byte returned after each packet.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  8  packet byte from handler.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  block can accept a byte.
- resp_data  output  8  response byte.
- resp_valid  output  1  response available.
- resp_ready  input  1  handler accepts response.
- scan_clk  output  1  scan-chain shift clock.
- scan_en  output  1  scan-chain shift enable.
- scan_in  output  1  serial data into the chain.
- scan_update  output  1  chain update/latch strobe.
- scan_out  input  1  serial data out of the chain (used only with the optional feature).
- busy  output  1  high in every state except COLLECT.

Behaviour:
- Reset: one clock (clk); reset_n is asynchronous and active-low.
  - Asserting reset_n=0 immediately forces state=COLLECT and clears byte_cnt, bit_cnt, div_cnt and the packet buffer.
  - Output values in reset: scan_clk=0, scan_en=0, scan_in=0, scan_update=0, resp_valid=0, resp_data=0, busy=0, in_ready=1.
  - A reset mid-shift abandons the packet; no response is produced.
- Outputs: all are registered except in_ready, which is (state==COLLECT).
- Handshake: a byte transfers on a cycle with in_valid && in_ready. in_valid outside COLLECT is ignored and nothing is stored.
- COLLECT:
  - Each transfer writes buffer[byte_cnt] and increments byte_cnt.
  - On the transfer with byte_cnt==PACKET_BYTES-1, go to SHIFT, clear byte_cnt, bit_cnt and div_cnt.
  - Latency: scan_en=1 and the first bit on scan_in appear the cycle after that last byte transfers.
- Bit order: buffer[0] is shifted first; each byte is sent MSB first. bit_cnt counts 0..8*PACKET_BYTES-1.
- SHIFT:
  - scan_en=1 throughout.
  - Each bit: scan_in is held stable; scan_clk=0 for CLK_DIV cycles, then scan_clk=1 for CLK_DIV cycles.
  - scan_in changes only on the cycle scan_clk falls, giving setup and hold of CLK_DIV cycles each.
  - After the high phase of the last bit, go to UPDATE. scan_clk returns to 0 and scan_en to 0 on the same cycle.
  - Total SHIFT duration is exactly 2*CLK_DIV*8*PACKET_BYTES cycles.
- UPDATE: scan_update=1 for exactly CLK_DIV cycles, with scan_en=0 and scan_clk=0, then go to RESPOND.
- RESPOND:
  - resp_valid=1 and resp_data=ACK_BYTE, held stable until resp_valid && resp_ready.
  - On the cycle after the transfer: resp_valid=0, state=COLLECT, in_ready=1.
  - A resp_ready that is already high at entry completes the transfer in the first RESPOND cycle.
- Counters: div_cnt is 8 bit and bit_cnt is 9 bit; neither wraps in legal operation. Any illegal state encoding recovers to COLLECT with outputs at their reset values.
- busy: 1 in SHIFT, UPDATE and RESPOND.

Optional Feature:
- Macro: ASC_SCAN_READBACK_EN.
- Defined:
  - scan_out is sampled on the last clk cycle of each scan_clk low phase, i.e. the cycle before scan_clk rises.
  - An 8-bit ones-counter counts the sampled 1s, cleared on entry to SHIFT and wrapping modulo 256.
  - In RESPOND, resp_data = ones-counter instead of ACK_BYTE.
- Undefined: scan_out is unused, no counter logic is built, and resp_data=ACK_BYTE.

Test Plan (CLK_DIV=2, PACKET_BYTES=22 unless noted):
- Basic shift:
  - Stimulus: send 8'h80 followed by 21 bytes of 8'h00, back-to-back.
  - Required: in_ready drops the cycle after the 22nd byte; exactly 176 scan_clk rising edges; scan_in=1 only for bit 0; scan_update high for 2 cycles; resp_valid with 8'hA5.
- Bit order:
  - Stimulus: send bytes 0x00..0x15.
  - Required: the bitstream captured at scan_clk rising edges equals each byte MSB first in index order; SHIFT lasts 704 cycles.
- Response backpressure:
  - Stimulus: hold resp_ready=0 for 10 cycles in RESPOND, then 1.
  - Required: resp_valid/resp_data stay 1/8'hA5 throughout; in_ready=1 the cycle after the transfer.
- Ignored input:
  - Stimulus: pulse in_valid with 8'hFF during SHIFT, then send a new 22-byte packet.
  - Required: the first scan stream is unaffected; the new packet is shifted exactly as sent.
- Async reset:
  - Stimulus: drop reset_n at bit 50 of SHIFT.
  - Required: all outputs go to reset values with no clk edge; no response; the next 22-byte packet shifts correctly from bit 0.
- Readback (ASC_SCAN_READBACK_EN defined):
  - Stimulus: tie scan_out=1.
  - Required: resp_data=8'hB0 (176).
  - Stimulus: loop scan_out to scan_in with all bytes 0x0F.
  - Required: resp_data=8'h58 (88).
